reduce_seq: RTL
===============

REDUCE_SEQ -- requirements
Module: reduce_seq

Interface
REQ-001 Parameter WIDTH, default 16, meaning input word width in bits.
REQ-002 Parameter CHUNK, default 4, meaning bits reduced per cycle; WIDTH SHALL be an integer multiple of CHUNK, CHUNK >= 1; N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in  input  WIDTH  word to reduce.
REQ-008 mode  input  2  operation: 00 OR, 01 AND, 10 XOR, 11 NOR.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out  output  1  reduction result.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1, out_valid=0; in_valid=1 at an edge SHALL latch in and mode, set acc to the identity (1 for AND, 0 otherwise), set chunk index idx=0, and go to RUN.
REQ-015 RUN: in_ready=0; each edge SHALL combine the latched chunk bits [idx*CHUNK +: CHUNK] into acc using the latched op (OR/NOR: OR; AND: AND; XOR: XOR), chunks processed LSB chunk first, idx incremented.
REQ-016 RUN SHALL go to DONE on the edge that processes chunk N-1; exactly N RUN cycles per request.
REQ-017 DONE: out_valid=1, out = acc for OR/AND/XOR and ~acc for NOR; out SHALL be stable while out_valid=1.
REQ-018 DONE with out_ready=1 at an edge SHALL return to IDLE; out_ready=0 SHALL hold DONE indefinitely.
REQ-019 Latency: out_valid SHALL rise exactly N cycles after the accepting edge; no request accepted in the cycle of the output handshake (in_ready rises the cycle after).
REQ-020 in_valid, in and mode changes while in RUN or DONE SHALL be ignored and SHALL NOT corrupt acc.
REQ-021 N=1 (CHUNK=WIDTH) SHALL work: single RUN cycle, out_valid one cycle after acceptance.
REQ-022 out SHALL be 0 whenever out_valid=0.
REQ-023 Result SHALL equal the combinational reduction of the latched word for every mode and parameter set.

Reset
REQ-024 reset=1 at an edge SHALL force IDLE from any state, clear acc, idx, latched data and mode to 0, regardless of in_valid/out_ready.
REQ-025 After reset: in_ready=1, out_valid=0, out=0, busy=0 from the next cycle.
REQ-026 Reset mid-RUN or in DONE SHALL discard the request; no out_valid pulse SHALL follow.
REQ-027 reset SHALL take priority over a simultaneous in_valid accept.

Verification (WIDTH=16, CHUNK=4, N=4 unless stated)
REQ-028 OR: in=0x8000 accepted -> out_valid high 4 cycles later, out=1; in=0x0000 -> out=0; NOR of 0x0000 -> out=1.
REQ-029 AND: in=0xFFFF -> out=1; in=0xFFFE -> out=0; XOR: in=0x0007 -> out=1, in=0x0003 -> out=0.
REQ-030 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out held, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-031 Busy ignore: new in_valid with in=0xFFFF, mode=AND during RUN of OR(0x0000) -> result out=0, second request not accepted.
REQ-032 Reset mid-RUN (after 2 RUN cycles) -> in_ready=1, busy=0 next cycle, no out_valid observed for 10 cycles.
REQ-033 Parameter sweep CHUNK=1, 16 (N=16, 1): random words and modes -> latency N, out matches reference reduction.

Source files
------------

// File: rtl/reduce_seq.sv
`default_nettype none
// ============================================================================
// Module      : reduce_seq
// Description : Sequential bit-reduction engine. A WIDTH-bit word is
//               accepted with a valid/ready handshake and reduced CHUNK bits
//               per clock (OR, AND, XOR or NOR), LSB chunk first. The 1-bit
//               result is held on out until the consumer takes it.
//
// Parameters  : WIDTH  input word width (must be an integer multiple of CHUNK)
//               CHUNK  bits folded into the accumulator per RUN cycle (>= 1)
//
// Ports       : clk        rising-edge clock
//               reset      synchronous active-high reset
//               in_valid   request present
//               in_ready   block can accept a request (IDLE)
//               in         word to reduce
//               mode       00 OR, 01 AND, 10 XOR, 11 NOR
//               out_valid  result available (DONE)
//               out_ready  consumer takes the result
//               out        reduction result, 0 while out_valid is low
//               busy       high whenever the FSM is not IDLE
//
// Revision    : 1.0  initial release
// ============================================================================
module reduce_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out,
    output logic             busy
);

    localparam int c_num_chunks = WIDTH / CHUNK;
    // A 1-bit index is kept even for a single chunk so no zero-width vector exists.
    localparam int c_idx_w      = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_num_chunks - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    localparam logic [1:0] c_mode_or  = 2'b00;
    localparam logic [1:0] c_mode_and = 2'b01;
    localparam logic [1:0] c_mode_xor = 2'b10;
    localparam logic [1:0] c_mode_nor = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_data;
    logic [1:0]          r_mode;
    logic                r_acc;
    logic [c_idx_w-1:0]  r_idx;
    logic [CHUNK-1:0]    w_chunk;
    logic                w_acc_next;

    // The latched word is shifted right one chunk per RUN cycle, so the chunk
    // being processed (index r_idx) always sits in the low CHUNK bits.
    assign w_chunk = r_data[CHUNK-1:0];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state, accumulator update and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc | (|w_chunk);
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out          = 1'b0;
        busy         = 1'b1;

        // NOR accumulates as OR; inversion happens only at the output.
        case (r_mode)
            c_mode_and: w_acc_next = r_acc & (&w_chunk);
            c_mode_xor: w_acc_next = r_acc ^ (^w_chunk);
            default:    w_acc_next = r_acc | (|w_chunk);
        endcase

        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_idx == c_last_idx) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out       = (r_mode == c_mode_nor) ? ~r_acc : r_acc;
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: capture on accept, fold one chunk per RUN cycle. Nothing is
    // written in DONE, which keeps out stable and ignores new requests.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_mode <= 2'b00;
            r_acc  <= 1'b0;
            r_idx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data <= in;
                        r_mode <= mode;
                        r_acc  <= (mode == c_mode_and);
                        r_idx  <= '0;
                    end
                end
                ST_RUN: begin
                    r_data <= r_data >> CHUNK;
                    r_acc  <= w_acc_next;
                    r_idx  <= r_idx + c_idx_one;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
